// File: rtl/fft_wr_pkg.sv
// Shared types and constants for the FFT result writer.
// State encoding, word-to-byte address shift and default widths.
package fft_wr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wr_state_t;

  localparam int WORD_SHIFT         = 2;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_FIFO_DEPTH     = 4;

endpackage

// File: rtl/fft_wr_fifo.sv
// Synchronous FIFO with registered full/empty flags and a sync clear.
// Latency: a push at edge N is visible at the head (empty=0) from cycle N+1.
// Backpressure: push ignored when full, pop ignored when empty; simultaneous push/pop keeps occupancy.
module fft_wr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic [PW:0]      cnt_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    if (do_push && !do_pop)
      cnt_nxt = cnt + CNT_ONE;
    else if (do_pop && !do_push)
      cnt_nxt = cnt - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == DEPTH_C);
      empty <= (cnt_nxt == '0);
    end
  end

  // Storage needs no reset: the flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fft_result_writer.sv
// Buffers FFT result words and writes them to offset + 4*index; done pulses once filesize words are written.
// Latency: word accepted at edge N may be presented on mem_we in cycle N+1; 1 word/cycle with ack held high.
// Backpressure: in_ready follows the registered FIFO full flag; writes hold until mem_ack. FFT_WR_BYTESWAP_EN byte-reverses mem_wdata.
module fft_result_writer
  import fft_wr_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] filesize,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  wr_state_t         state_q;
  wr_state_t         state_d;
  logic [ADDR_W-1:0] offset_q;
  logic [ADDR_W-1:0] filesize_q;
  logic [ADDR_W-1:0] acc_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic              start_take;
  logic              accept;
  logic              pop;
  logic              fifo_full_q;
  logic              fifo_empty_q;
  logic [DATA_W-1:0] head_dat;
  logic [DATA_W-1:0] head_fmt;

  assign accept = in_valid && in_ready;
  assign pop    = mem_we && mem_ack;

  fft_wr_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_take),
    .push     (accept),
    .push_dat (in_data),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full_q),
    .empty    (fifo_empty_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // in_ready depends only on registered state, never on mem_ack.
  always_comb begin
    state_d    = state_q;
    start_take = 1'b0;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_take = 1'b1;
          state_d    = (filesize == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = !fifo_full_q && (acc_cnt < filesize_q);
        mem_we   = !fifo_empty_q;
        if (in_valid && !fifo_full_q && (acc_cnt < filesize_q)
            && (acc_cnt + CNT_ONE == filesize_q))
          state_d = FLUSH;
      end
      FLUSH: begin
        busy   = 1'b1;
        mem_we = !fifo_empty_q;
        if (!fifo_empty_q && mem_ack && (wr_cnt + CNT_ONE == filesize_q))
          state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q   <= '0;
      filesize_q <= '0;
      acc_cnt    <= '0;
      wr_cnt     <= '0;
    end else if (start_take) begin
      offset_q   <= offset;
      filesize_q <= filesize;
      acc_cnt    <= '0;
      wr_cnt     <= '0;
    end else begin
      if (accept) acc_cnt <= acc_cnt + CNT_ONE;
      if (pop)    wr_cnt  <= wr_cnt + CNT_ONE;
    end
  end

`ifdef FFT_WR_BYTESWAP_EN
  always_comb begin
    head_fmt = '0;
    for (int b = 0; b < DATA_W/8; b++)
      head_fmt[DATA_W-1-8*b -: 8] = head_dat[8*b +: 8];
  end
`else
  assign head_fmt = head_dat;
`endif

  // Address wraps silently modulo 2^ADDR_W; outputs are zero while no write is pending.
  assign mem_addr  = mem_we ? (offset_q + (wr_cnt << WORD_SHIFT)) : '0;
  assign mem_wdata = mem_we ? head_fmt : '0;

endmodule

// File: doc/fft_result_writer.md
Name: fft_result_writer

Overview:
- Write-side counterpart of the FFT read address calculator.
- Accepts FFT result words on a valid/ready stream and buffers them in a small FIFO.
- Issues word-aligned memory writes at offset + (index << 2) with a stallable ack handshake.
- Signals done once filesize words have been written. Sits between the FFT core output and the data memory port of the data control router.

Parameters:
- DATA_W, 32, width of result words and mem_wdata
- ADDR_W, 32, width of offset, filesize and mem_addr
- FIFO_DEPTH, 4, buffer entries; power of two, minimum 2

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; latches offset/filesize; honoured only in IDLE
- offset  in  ADDR_W  base byte address of the result region
- filesize  in  ADDR_W  number of words to write
- in_data  in  DATA_W  FFT result word
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  DATA_W  write data
- mem_we  out  1  write request; held until mem_ack
- mem_ack  in  1  memory accepted the current write
- busy  out  1  high in RUN and FLUSH
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (clk edge with rst=1): state IDLE, FIFO emptied, counters cleared.
- Output values under reset: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: start=1 latches offset/filesize, clears acc_cnt and wr_cnt.
  - filesize==0 goes to DONE.
  - Otherwise goes to RUN. Input is not accepted in the start cycle.
- RUN: in_ready = !fifo_full_q && (acc_cnt < filesize_q). fifo_full_q is the registered full flag.
  - A pop in the same cycle does not raise in_ready; no combinational path from mem_ack to in_ready.
  - Accept = in_valid && in_ready: push the word, acc_cnt++.
  - When acc_cnt reaches filesize_q, go to FLUSH.
- FLUSH: in_ready=0. Memory side keeps draining.
- Memory side (RUN and FLUSH): mem_we = FIFO non-empty.
  - mem_wdata = FIFO head.
  - mem_addr = offset_q + (wr_cnt << 2), modulo 2^ADDR_W; wrap is silent.
  - mem_we && mem_ack pops the FIFO and increments wr_cnt.
  - mem_addr, mem_wdata and mem_we must stay stable while mem_we=1 and mem_ack=0.
  - mem_ack while mem_we=0 is ignored.
- Latency: a word accepted at edge N may appear on mem_we/mem_wdata in cycle N+1. Zero-bubble throughput of 1 word/cycle when mem_ack is held high.
- Push and pop in the same cycle: both take effect; occupancy is unchanged.
- Completion: the pop that makes wr_cnt == filesize_q moves to DONE.
  - DONE lasts exactly one cycle with done=1 and busy=0, then returns to IDLE.
- start outside IDLE is ignored, including in the DONE cycle.
- rst asserted mid-operation: returns to IDLE on that edge. Buffered words are discarded. mem_we is low from the next cycle. A pending write is abandoned.
- Counters are ADDR_W wide. filesize up to 2^ADDR_W-1 is supported.

Optional Feature:
- Macro FFT_WR_BYTESWAP_EN.
- Defined: mem_wdata is the byte-reversed FIFO head (bits 7:0 go to DATA_W-1:DATA_W-8, and so on). DATA_W must be a multiple of 8. Used for big-endian memory images.
- Undefined: mem_wdata equals the FIFO head unchanged. No extra logic or latency in either case.

Decomposition:
- Shared package fft_wr_pkg:
  - state encoding constants (IDLE=0, RUN=1, FLUSH=2, DONE=3)
  - WORD_SHIFT=2
  - default widths
- One sub-module: fft_wr_fifo, a synchronous FIFO.
  - Parameters: width and depth.
  - Ports: push, pop, registered full/empty, head data, sync clear.
- The address adder stays inline in the top.

Test Plan:
- Basic run: offset=0x1000, filesize=4, data 0xA0..0xA3, in_valid and mem_ack held high.
  - Writes to 0x1000, 0x1004, 0x1008, 0x100C in order with matching data.
  - done pulses 1 cycle after the 4th ack; busy low in that cycle.
- Backpressure: mem_ack=0 for 10 cycles, filesize=8.
  - in_ready drops after 4 accepts.
  - mem_addr/wdata held stable throughout.
  - Releasing ack completes all 8 writes with no loss or duplication.
- Zero size: filesize=0 with start gives done on the cycle after start.
  - mem_we and in_ready never assert.
- Wrap: offset=0xFFFFFFF8, filesize=4.
  - Addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Reset mid-run: rst after 3 of 6 writes.
  - Next cycle mem_we=0, in_ready=0, busy=0.
  - A new start with offset=0x2000, filesize=2 writes 0x2000, 0x2004 only.
- Macro defined, in_data=0x11223344: mem_wdata=0x44332211. Start pulsed during RUN is ignored.
